// File: rtl/if_id_buf_if.sv
// Valid/ready beat carrying an instruction and its PC between pipeline stages.
interface if_id_buf_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            valid;
    logic            ready;

    modport master (output inst, output pc, output valid, input ready);
    modport slave  (input inst, input pc, input valid, output ready);
endinterface

// File: rtl/if_id_buf.sv
// IF/ID pipeline buffer: registers fetched inst/pc behind valid/ready, flushes on taken branch.
// IF_ID_SKID_EN defined: two entries (main + skid) with registered ready; undefined: single entry.
module if_id_buf #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] NOP_INST = XLEN'(32'h0000_0013)
) (
    input  logic          clk,
    input  logic          rst_n,
    if_id_buf_if.slave    fe,
    if_id_buf_if.master   de,
    input  logic          flush_i
);
    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } beat_t;

    // bit0 = main valid, bit1 = skid valid, so both flags come straight from flops
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t state_q, state_d;
    beat_t  main_q, in_beat;
    logic   in_fire, out_fire, load_main, clr_pc;

    assign in_beat  = {fe.inst, fe.pc};
    assign in_fire  = fe.valid & fe.ready;
    assign out_fire = de.valid & de.ready;

    assign de.valid = state_q[0];
    assign de.inst  = state_q[0] ? main_q.inst : NOP_INST;
    assign de.pc    = main_q.pc;

`ifdef IF_ID_SKID_EN
    beat_t skid_q;
    logic  load_skid, pop_skid;

    assign fe.ready = ~state_q[1];
`else
    assign fe.ready = de.ready | ~state_q[0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        clr_pc    = 1'b0;
`ifdef IF_ID_SKID_EN
        load_skid = 1'b0;
        pop_skid  = 1'b0;
`endif
        if (flush_i) begin
            state_d = EMPTY;
            clr_pc  = state_q[0];   // flushing an empty buffer leaves pc_o alone
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        load_main = 1'b1;
                        state_d   = ONE;
                    end
                end
                ONE: begin
`ifdef IF_ID_SKID_EN
                    if (in_fire && out_fire) begin
                        load_main = 1'b1;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end else if (in_fire) begin
                        load_skid = 1'b1;
                        state_d   = FULL;
                    end
`else
                    // ready_o tracks ready_i here, so in_fire implies out_fire
                    if (in_fire)       load_main = 1'b1;
                    else if (out_fire) state_d   = EMPTY;
`endif
                end
                FULL: begin
`ifdef IF_ID_SKID_EN
                    if (out_fire) begin
                        pop_skid = 1'b1;
                        state_d  = ONE;
                    end
`else
                    state_d = EMPTY;
`endif
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         main_q <= '{inst: NOP_INST, pc: RESET_PC};
        else if (clr_pc)    main_q.pc <= RESET_PC;
        else if (load_main) main_q <= in_beat;
`ifdef IF_ID_SKID_EN
        else if (pop_skid)  main_q <= skid_q;
`endif
    end

`ifdef IF_ID_SKID_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         skid_q <= '0;
        else if (load_skid) skid_q <= in_beat;
    end
`endif
endmodule
